// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [0:0] {StIdle, StAccess} arb_state_e;

    localparam logic PortCpu = 1'b0;
    localparam logic PortDbg = 1'b1;

    localparam int unsigned DefaultAw       = 8;
    localparam int unsigned DefaultDw       = 32;
    localparam int unsigned DefaultMemWords = 64;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time goes.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && (!req_i[1] || last_i == PortDbg)) begin
            gnt_o[0] = 1'b1;
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and debug/DMA loader (port 1).
// Define DMEM_ARB_STATS_EN to add per-port grant counters and a tie-conflict counter.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = DefaultAw,
    parameter int unsigned DW        = DefaultDw,
    parameter int unsigned MEM_WORDS = DefaultMemWords
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          rerr0_o,
    output logic          rerr1_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   gcnt0_o,
    output logic [15:0]   gcnt1_o,
    output logic [15:0]   conflict_cnt_o
`endif
);

    arb_state_e    state_q;
    logic          last_q;
    logic          cap_we_q;
    logic          cap_port_q;
    logic [AW-1:0] cap_addr_q;
    logic [DW-1:0] cap_wdata_q;
    logic          rvalid0_q, rvalid1_q;
    logic          rerr0_q, rerr1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic [1:0]    arb_gnt;
    logic          idle;
    logic          access;
    logic          addr_ok;
    logic [DW-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req_i  ({req1_i, req0_i}),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    // Reset gates the combinational outputs so nothing is granted or strobed in a reset cycle.
    assign idle    = (state_q == StIdle) && !rst_i;
    assign access  = (state_q == StAccess) && !rst_i;
    assign addr_ok = cap_addr_q < AW'(MEM_WORDS);

    assign gnt0_o      = idle && arb_gnt[0];
    assign gnt1_o      = idle && arb_gnt[1];
    assign mem_read_o  = access && addr_ok && !cap_we_q;
    assign mem_write_o = access && addr_ok && cap_we_q;
    assign mem_addr_o  = access ? cap_addr_q : '0;
    assign mem_wdata_o = access ? cap_wdata_q : '0;

    assign resp_data = (addr_ok && !cap_we_q) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_q      <= PortDbg;
            cap_we_q    <= 1'b0;
            cap_port_q  <= PortCpu;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rerr0_q     <= 1'b0;
            rerr1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|arb_gnt) begin
                        state_q     <= StAccess;
                        last_q      <= arb_gnt[1] ? PortDbg : PortCpu;
                        cap_port_q  <= arb_gnt[1] ? PortDbg : PortCpu;
                        cap_we_q    <= arb_gnt[1] ? we1_i : we0_i;
                        cap_addr_q  <= arb_gnt[1] ? addr1_i : addr0_i;
                        cap_wdata_q <= arb_gnt[1] ? wdata1_i : wdata0_i;
                    end
                end
                StAccess: begin
                    state_q <= StIdle;
                    if (cap_port_q == PortDbg) begin
                        rvalid1_q <= 1'b1;
                        rerr1_q   <= !addr_ok;
                        rdata1_q  <= resp_data;
                    end else begin
                        rvalid0_q <= 1'b1;
                        rerr0_q   <= !addr_ok;
                        rdata0_q  <= resp_data;
                    end
                end
            endcase
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rerr0_o   = rerr0_q;
    assign rerr1_o   = rerr1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q, conflict_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcnt0_q    <= '0;
            gcnt1_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (gnt0_o && gcnt0_q != 16'hFFFF) begin
                gcnt0_q <= gcnt0_q + 16'd1;
            end
            if (gnt1_o && gcnt1_q != 16'hFFFF) begin
                gcnt1_q <= gcnt1_q + 16'd1;
            end
            if (idle && req0_i && req1_i && conflict_q != 16'hFFFF) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    assign gcnt0_o        = gcnt0_q;
    assign gcnt1_o        = gcnt1_q;
    assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1, conflict_cnt;
`endif

    logic [31:0] bank [256];
    logic        bank_init;
    int          checks = 0;
    int          failures = 0;
    int          gseq[$];

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req0_i      (req0),
        .req1_i      (req1),
        .we0_i       (we0),
        .we1_i       (we1),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .rerr0_o     (rerr0),
        .rerr1_o     (rerr1),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .gcnt0_o        (gcnt0),
        .gcnt1_o        (gcnt1),
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    // Behavioural bank: combinational read, write on rising edge, mem[i]=i when initialised.
    assign mem_rdata = bank[mem_addr];
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 256; i++) bank[i] <= 32'(i);
        end else if (mem_write) begin
            bank[mem_addr] <= mem_wdata;
        end
    end

    task automatic drive_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset;
        rst = 1; bank_init = 1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0; bank_init = 0;
    endtask

    task automatic test_reset;
        rst = 1; bank_init = 1;
        clear_inputs();
        req0 = 1; req1 = 1;
        drive_clk();
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write} !== 6'b0 ||
            mem_addr !== 0 || mem_wdata !== 0 || rdata0 !== 0 || rdata1 !== 0 ||
            {rerr1, rerr0} !== 2'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b strobes=%b%b addr=%h rdata=%h/%h, want all 0",
                     gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write, mem_addr, rdata0, rdata1);
        end
        req0 = 0; req1 = 0;
        drive_clk();
        rst = 0; bank_init = 0;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write} !== 6'b0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b%b rv=%b%b strobes=%b%b, want 0",
                     gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write);
        end
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (gcnt0 !== 0 || gcnt1 !== 0 || conflict_cnt !== 0) begin
            failures++;
            $display("FAIL reset_stats: gcnt=%0d/%0d conflict=%0d, want 0/0/0", gcnt0, gcnt1, conflict_cnt);
        end
`endif
        drive_clk();
    endtask

    task automatic test_single_read;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'd5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL s1_gnt: gnt1/gnt0=%b%b, want 01", gnt1, gnt0);
        end
        drive_clk();
        req0 = 0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'd5) begin
            failures++;
            $display("FAIL s1_strobe: rd=%b wr=%b addr=%0d, want 1 0 5", mem_read, mem_write, mem_addr);
        end
        drive_clk();
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'd5 || rerr0 !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL s1_resp: rvalid0=%b rdata0=%h rerr0=%b rd=%b, want 1 5 0 0",
                     rvalid0, rdata0, rerr0, mem_read);
        end
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 0 || rerr1 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL s1_port1_quiet: rvalid1=%b rdata1=%h rerr1=%b gnt1=%b, want 0",
                     rvalid1, rdata1, rerr1, gnt1);
        end
    endtask

    task automatic test_tie_first;
        int rv0_t = -1;
        int rv1_t = -1;
        logic [31:0] d0 = 0;
        logic [31:0] d1 = 0;
        logic g;
        do_reset();
        req0 = 1; addr0 = 8'd3; req1 = 1; addr1 = 8'd7;
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            failures++;
            $display("FAIL s2_first_tie: gnt1/gnt0=%b%b, want 01", gnt1, gnt0);
        end
        drive_clk();
        req0 = 0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            g = gnt1;
            if (rvalid0) begin rv0_t = t; d0 = rdata0; end
            if (rvalid1) begin rv1_t = t; d1 = rdata1; end
            drive_clk();
            if (g) req1 = 0;
        end
        checks++;
        if (rv0_t != 2 || d0 !== 32'd3) begin
            failures++;
            $display("FAIL s2_port0_resp: cycle=%0d rdata0=%h, want 2 00000003", rv0_t, d0);
        end
        checks++;
        if (rv1_t - rv0_t != 2 || d1 !== 32'd7) begin
            failures++;
            $display("FAIL s2_port1_resp: gap=%0d rdata1=%h, want 2 00000007", rv1_t - rv0_t, d1);
        end
    endtask

    task automatic test_write_then_read;
        int wcnt = 0;
        bit got0 = 0;
        bit got1 = 0;
        logic [31:0] d0 = 0;
        logic [31:0] d1 = 32'hFFFF_FFFF;
        logic g0, g1, rv1;
        do_reset();
        req1 = 1; we1 = 1; addr1 = 8'd10; wdata1 = 32'hDEAD_BEEF;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (mem_write) wcnt++;
            g0 = gnt0; g1 = gnt1; rv1 = rvalid1;
            if (rvalid1) begin got1 = 1; d1 = rdata1; end
            if (rvalid0) begin got0 = 1; d0 = rdata0; end
            drive_clk();
            if (g1) req1 = 0;
            if (g0) req0 = 0;
            if (rv1) begin req0 = 1; we0 = 0; addr0 = 8'd10; end
        end
        checks++;
        if (wcnt != 1) begin
            failures++;
            $display("FAIL s3_write_pulse: mem_write cycles=%0d, want 1", wcnt);
        end
        checks++;
        if (!got1 || d1 !== 0) begin
            failures++;
            $display("FAIL s3_write_resp: seen=%0b rdata1=%h, want 1 00000000", got1, d1);
        end
        checks++;
        if (!got0 || d0 !== 32'hDEAD_BEEF || bank[10] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL s3_read_back: seen=%0b rdata0=%h bank=%h, want deadbeef", got0, d0, bank[10]);
        end
    endtask

    task automatic test_out_of_range;
        bit strobe, got;
        logic g, e;
        logic [31:0] d;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            strobe = 0; got = 0; e = 0; d = 32'hFFFF_FFFF;
            req0 = 1; we0 = k[0]; addr0 = (k == 0) ? 8'd64 : 8'd70; wdata0 = 32'h1234_5678;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                if (mem_read || mem_write) strobe = 1;
                g = gnt0;
                if (rvalid0) begin got = 1; d = rdata0; e = rerr0; end
                drive_clk();
                if (g) req0 = 0;
            end
            checks++;
            if (strobe || !got || e !== 1'b1 || d !== 0) begin
                failures++;
                $display("FAIL s4_oor_%0d: strobe=%0b seen=%0b rerr0=%b rdata0=%h, want 0 1 1 0",
                         k, strobe, got, e, d);
            end
        end
        checks++;
        if (bank[64] !== 32'd64 || bank[70] !== 32'd70) begin
            failures++;
            $display("FAIL s4_bank_intact: bank[64]=%h bank[70]=%h, want 40 46", bank[64], bank[70]);
        end
    endtask

    task automatic test_reset_mid_access;
        do_reset();
        req0 = 1; we0 = 1; addr0 = 8'd20; wdata0 = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL s6_gnt: gnt0=%b, want 1", gnt0);
        end
        drive_clk();
        req0 = 0; rst = 1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL s6_strobe_drop: rd=%b wr=%b, want 0 0", mem_read, mem_write);
        end
        drive_clk();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({rvalid1, rvalid0, mem_read, mem_write, gnt1, gnt0} !== 6'b0 || bank[20] !== 32'd20) begin
            failures++;
            $display("FAIL s6_after: rv=%b%b strobes=%b%b gnt=%b%b bank[20]=%h, want 0 and 14",
                     rvalid1, rvalid0, mem_read, mem_write, gnt1, gnt0, bank[20]);
        end
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (gcnt0 !== 0 || gcnt1 !== 0 || conflict_cnt !== 0) begin
            failures++;
            $display("FAIL s6_stats: gcnt=%0d/%0d conflict=%0d, want 0/0/0", gcnt0, gcnt1, conflict_cnt);
        end
`endif
        drive_clk();
        req1 = 1; we1 = 0; addr1 = 8'd20;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL s6_idle_again: gnt1=%b, want 1", gnt1);
        end
        drive_clk();
        req1 = 0;
        drive_clk();
        @(negedge clk);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'd20) begin
            failures++;
            $display("FAIL s6_read: rvalid1=%b rdata1=%h, want 1 00000014", rvalid1, rdata1);
        end
        drive_clk();
    endtask

    // Cycle-level model: a free arbiter grants per round-robin, strobes one cycle later,
    // responds two cycles later; memory effects are applied in grant order.
    task automatic run_model(input int n, input bit hold_both);
        bit          pend[2];
        logic        pwe[2];
        logic [7:0]  pad[2];
        logic [31:0] pwd[2];
        logic [31:0] ref_mem[256];
        bit          a_v[4], a_we[4], a_err[4];
        logic [7:0]  a_addr[4];
        logic [31:0] a_wd[4];
        bit          r_v[4], r_port[4], r_err[4];
        logic [31:0] r_data[4];
        int          next_free, win, s, cc, bad;
        int          gc[2];
        bit          last, e0, e1, err;
        for (int i = 0; i < 256; i++) ref_mem[i] = bank[i];
        for (int i = 0; i < 4; i++) begin a_v[i] = 0; r_v[i] = 0; end
        for (int p = 0; p < 2; p++) begin pend[p] = 0; pwe[p] = 0; pad[p] = 0; pwd[p] = 0; gc[p] = 0; end
        next_free = 0; last = 1; cc = 0;
        for (int t = 0; t < n + 4; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (t >= n) begin
                    pend[p] = 0;
                end else if (pend[p] && !hold_both && $urandom_range(0, 7) == 0) begin
                    pend[p] = 0;
                end else if (!pend[p] && (hold_both || $urandom_range(0, 2) != 0)) begin
                    pend[p] = 1;
                    pwe[p]  = hold_both ? 1'b0 : 1'($urandom_range(0, 1));
                    pad[p]  = 8'($urandom_range(0, hold_both ? 63 : 79));
                    pwd[p]  = $urandom;
                end
            end
            req0 = pend[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pwd[0];
            req1 = pend[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pwd[1];
            @(negedge clk);
            s = t % 4;
            win = -1;
            if (t >= next_free) begin
                if (pend[0] && pend[1]) begin win = last ? 0 : 1; cc++; end
                else if (pend[0]) win = 0;
                else if (pend[1]) win = 1;
            end
            checks++;
            if (gnt0 !== (win == 0) || gnt1 !== (win == 1)) begin
                failures++;
                $display("FAIL rnd_gnt t=%0d: gnt1/gnt0=%b%b, want port %0d", t, gnt1, gnt0, win);
            end
            checks++;
            if (a_v[s]) begin
                if (mem_read !== (!a_err[s] && !a_we[s]) || mem_write !== (!a_err[s] && a_we[s]) ||
                    (!a_err[s] && mem_addr !== a_addr[s]) ||
                    (!a_err[s] && a_we[s] && mem_wdata !== a_wd[s])) begin
                    failures++;
                    $display("FAIL rnd_access t=%0d: rd=%b wr=%b addr=%h wd=%h, want we=%0b err=%0b addr=%h wd=%h",
                             t, mem_read, mem_write, mem_addr, mem_wdata, a_we[s], a_err[s], a_addr[s], a_wd[s]);
                end
            end else if (mem_read !== 0 || mem_write !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
                failures++;
                $display("FAIL rnd_quiet_bus t=%0d: rd=%b wr=%b addr=%h wd=%h, want 0",
                         t, mem_read, mem_write, mem_addr, mem_wdata);
            end
            e0 = r_v[s] && !r_port[s];
            e1 = r_v[s] && r_port[s];
            checks++;
            if (rvalid0 !== e0 || rdata0 !== (e0 ? r_data[s] : 32'd0) || rerr0 !== (e0 && r_err[s]) ||
                rvalid1 !== e1 || rdata1 !== (e1 ? r_data[s] : 32'd0) || rerr1 !== (e1 && r_err[s])) begin
                failures++;
                $display("FAIL rnd_resp t=%0d: rv=%b%b rdata=%h/%h rerr=%b%b, want rv=%b%b data=%h err=%b",
                         t, rvalid1, rvalid0, rdata0, rdata1, rerr1, rerr0, e1, e0, r_data[s], r_err[s]);
            end
            a_v[s] = 0;
            r_v[s] = 0;
            if (win >= 0) begin
                gc[win]++;
                last = win[0];
                next_free = t + 2;
                pend[win] = 0;
                if (hold_both) gseq.push_back(win);
                err = pad[win] >= 8'd64;
                a_v[(t + 1) % 4]    = 1;
                a_we[(t + 1) % 4]   = pwe[win];
                a_err[(t + 1) % 4]  = err;
                a_addr[(t + 1) % 4] = pad[win];
                a_wd[(t + 1) % 4]   = pwd[win];
                r_v[(t + 2) % 4]    = 1;
                r_port[(t + 2) % 4] = win[0];
                r_err[(t + 2) % 4]  = err;
                r_data[(t + 2) % 4] = (err || pwe[win]) ? 32'd0 : ref_mem[pad[win]];
                if (!err && pwe[win]) ref_mem[pad[win]] = pwd[win];
            end
            drive_clk();
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (bank[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rnd_bank_contents: %0d words differ, want 0", bad);
        end
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (gcnt0 !== 16'(gc[0]) || gcnt1 !== 16'(gc[1]) || conflict_cnt !== 16'(cc)) begin
            failures++;
            $display("FAIL rnd_stats: gcnt=%0d/%0d conflict=%0d, want %0d/%0d/%0d",
                     gcnt0, gcnt1, conflict_cnt, gc[0], gc[1], cc);
        end
`endif
    endtask

    task automatic test_alternation;
        int bad = 0;
        do_reset();
        gseq.delete();
        run_model(16, 1'b1);
        for (int i = 0; i < gseq.size(); i++) if (gseq[i] != i % 2) bad++;
        checks++;
        if (gseq.size() != 8 || bad != 0) begin
            failures++;
            $display("FAIL s5_alternation: grants=%0d out_of_order=%0d, want 8 0", gseq.size(), bad);
        end
    endtask

    task automatic test_random;
        do_reset();
        run_model(400, 1'b0);
    endtask

    initial begin
        rst = 1; bank_init = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie_first();
        test_write_then_read();
        test_out_of_range();
        test_alternation();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
